// File: rtl/stoch_signed_decoder_pkg.sv
// Shared types and helpers for the signed stochastic decoder.
// A signed stochastic value is carried on two lines: x_p (positive) and
// x_m (negative). Each clock contributes +1, -1 or 0 to a window sum.
package stoch_signed_decoder_pkg;

    // Width of the per-sample contribution (+1 / 0 / -1 as two's complement)
    localparam int STOCH_DELTA_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } stoch_dec_state_t;

    // Per-sample contribution of a (p, m) pair; both high cancels to zero
    function automatic logic signed [STOCH_DELTA_W-1:0] stoch_signed_delta(
        input logic p,
        input logic m
    );
        logic signed [STOCH_DELTA_W-1:0] d;
        case ({p, m})
            2'b10:   d = 2'sb01;
            2'b01:   d = 2'sb11;
            default: d = 2'sb00;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/stoch_signed_updown_counter.sv
// Signed accumulator that adds a +1/0/-1 step when enabled and can be
// cleared synchronously. Clear has priority over counting.
module stoch_signed_updown_counter
    import stoch_signed_decoder_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic                            CLK,
    input  logic                            nRST,
    input  logic                            clr,
    input  logic                            en,
    input  logic signed [STOCH_DELTA_W-1:0] delta,
    output logic signed [WIDTH-1:0]         value
);

    logic signed [WIDTH-1:0] value_q;
    logic signed [WIDTH-1:0] value_d;
    logic signed [WIDTH-1:0] delta_ext_s;

    // Next accumulator value: clear, step by the sign-extended delta, or hold
    always_comb begin
        delta_ext_s = {{(WIDTH-STOCH_DELTA_W){delta[STOCH_DELTA_W-1]}}, delta};
        value_d     = value_q;
        if (clr) begin
            value_d = {WIDTH{1'b0}};
        end else if (en) begin
            value_d = value_q + delta_ext_s;
        end else begin
            value_d = value_q;
        end
    end

    // Accumulator register with asynchronous reset to zero
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            value_q <= {WIDTH{1'b0}};
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/stoch_signed_decoder.sv
// Signed stochastic-to-binary decoder. Sums the +1/0/-1 contributions of
// an (x_p, x_m) stream over a window of 2^WINDOW_BITS cycles and presents
// the signed total on y with a one-cycle y_valid pulse. The window can run
// once per start pulse or back-to-back without a gap cycle.
module stoch_signed_decoder
    import stoch_signed_decoder_pkg::*;
#(
    parameter int WINDOW_BITS = 8,
    parameter int CONTINUOUS  = 0
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          start,
    input  logic                          clear,
    input  logic                          x_p,
    input  logic                          x_m,
    output logic                          busy,
    output logic signed [WINDOW_BITS+1:0] y,
    output logic                          y_valid
);

    // |sum| <= 2^WINDOW_BITS needs WINDOW_BITS+1 magnitude bits plus sign
    localparam int YW = WINDOW_BITS + 2;
    localparam logic [WINDOW_BITS-1:0] CNT_LAST = {WINDOW_BITS{1'b1}};
    localparam logic [WINDOW_BITS-1:0] CNT_ZERO = {WINDOW_BITS{1'b0}};
    localparam logic [WINDOW_BITS-1:0] CNT_ONE  = WINDOW_BITS'(1);

    stoch_dec_state_t state_q, state_d;
    logic [WINDOW_BITS-1:0]          cnt_q, cnt_d;
    logic signed [YW-1:0]            y_q, y_d;
    logic                            y_valid_q, y_valid_d;
    logic                            busy_q, busy_d;

    logic signed [STOCH_DELTA_W-1:0] delta_s;
    logic signed [YW-1:0]            delta_ext_s;
    logic signed [YW-1:0]            acc_s;
    logic                            acc_clr_s;
    logic                            acc_en_s;

    // Running window sum; cleared at window start, abort and window end
    stoch_signed_updown_counter #(
        .WIDTH (YW)
    ) u_acc (
        .CLK   (CLK),
        .nRST  (nRST),
        .clr   (acc_clr_s),
        .en    (acc_en_s),
        .delta (delta_s),
        .value (acc_s)
    );

    // Next-state, counter and result logic; clear overrides everything
    always_comb begin
        delta_s     = stoch_signed_delta(x_p, x_m);
        delta_ext_s = {{(YW-STOCH_DELTA_W){delta_s[STOCH_DELTA_W-1]}}, delta_s};
        state_d     = state_q;
        cnt_d       = cnt_q;
        y_d         = y_q;
        y_valid_d   = 1'b0;
        acc_clr_s   = 1'b0;
        acc_en_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d   = IDLE;
                    cnt_d     = CNT_ZERO;
                    acc_clr_s = 1'b1;
                end else if (start) begin
                    state_d   = ACCUM;
                    cnt_d     = CNT_ZERO;
                    acc_clr_s = 1'b1;
                end else begin
                    state_d   = IDLE;
                end
            end
            ACCUM: begin
                if (clear) begin
                    state_d   = IDLE;
                    cnt_d     = CNT_ZERO;
                    acc_clr_s = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    // Final sample is folded straight into the result so
                    // the accumulator can restart on the same edge
                    y_d       = acc_s + delta_ext_s;
                    y_valid_d = 1'b1;
                    cnt_d     = CNT_ZERO;
                    acc_clr_s = 1'b1;
                    state_d   = (CONTINUOUS != 0) ? ACCUM : IDLE;
                end else begin
                    acc_en_s  = 1'b1;
                    cnt_d     = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = CNT_ZERO;
                acc_clr_s = 1'b1;
            end
        endcase
        busy_d = (state_d == ACCUM);
    end

    // Controller registers: state, sample counter and registered outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            y_q       <= {YW{1'b0}};
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            busy_q    <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_stoch_signed_decoder.sv
// Bench for stoch_signed_decoder: one one-shot instance and one continuous
// instance, W = 256. Expected window sums are queued when a window starts
// and compared when y_valid appears.
module tb_stoch_signed_decoder;

    localparam int WB = 8;
    localparam int W  = 256;

    logic clk = 1'b0;
    logic nRST;

    logic start0, clear0, xp0, xm0, busy0, yv0;
    logic signed [WB+1:0] y0;
    logic start1, clear1, xp1, xm1, busy1, yv1;
    logic signed [WB+1:0] y1;

    stoch_signed_decoder #(.WINDOW_BITS(WB), .CONTINUOUS(0)) u_dut0 (
        .CLK(clk), .nRST(nRST), .start(start0), .clear(clear0),
        .x_p(xp0), .x_m(xm0), .busy(busy0), .y(y0), .y_valid(yv0)
    );

    stoch_signed_decoder #(.WINDOW_BITS(WB), .CONTINUOUS(1)) u_dut1 (
        .CLK(clk), .nRST(nRST), .start(start1), .clear(clear1),
        .x_p(xp1), .x_m(xm1), .busy(busy1), .y(y1), .y_valid(yv1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int pulses0 = 0;
    int pulses1 = 0;
    int last_pulse1 = -1;
    int q0[$];
    int q1[$];
    logic [1:0] win_bits [W];
    int last_y0 = 0;

    typedef struct {
        int pat;
        int exp_y;
        bit use_model;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string nm, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: advance, then look at both DUTs away from the edge
    task automatic tick();
        int e;
        @(posedge clk);
        #1;
        cyc++;
        if (yv0 === 1'b1) begin
            pulses0++;
            if (q0.size() == 0) begin
                check("unexpected_y_valid0", 1, 0);
            end else begin
                e = q0.pop_front();
                check("y0", y0, e);
                last_y0 = e;
            end
        end
        if (yv1 === 1'b1) begin
            pulses1++;
            if (last_pulse1 >= 0) check("pulse_gap1", cyc - last_pulse1, W);
            last_pulse1 = cyc;
            if (q1.size() == 0) begin
                check("unexpected_y_valid1", 1, 0);
            end else begin
                e = q1.pop_front();
                check("y1", y1, e);
            end
        end
    endtask

    function automatic logic [1:0] pat_bits(input int pat, input int i);
        logic [31:0] r;
        case (pat)
            0: return 2'b10;
            1: return 2'b01;
            2: return 2'b11;
            3: return {((i % 2) == 0), 1'b0};
            4: return {1'b0, ((i % 4) == 3)};
            6: return 2'b00;
            default: begin
                r = $urandom();
                return r[1:0];
            end
        endcase
    endfunction

    // Fill the window stimulus and compute its expected signed sum
    task automatic fill_window(input int pat, output int sum);
        logic [1:0] b;
        sum = 0;
        for (int i = 0; i < W; i++) begin
            b = pat_bits(pat, i);
            win_bits[i] = b;
            if (b == 2'b10) sum = sum + 1;
            else if (b == 2'b01) sum = sum - 1;
        end
    endtask

    // One-shot window on the CONTINUOUS=0 instance with timing checks
    task automatic run_oneshot(input int pat, input int texp, input bit use_model);
        int mexp, e, p_start;
        fill_window(pat, mexp);
        e = use_model ? mexp : texp;
        start0 = 1'b1;
        q0.push_back(e);
        tick();
        start0 = 1'b0;
        check("busy_after_start", busy0, 1);
        p_start = pulses0;
        for (int i = 0; i < W; i++) begin
            {xp0, xm0} = win_bits[i];
            start0 = (i == 10);  // must be ignored mid-window
            if (i == W - 1) check("early_pulse", pulses0 - p_start, 0);
            tick();
        end
        start0 = 1'b0;
        check("pulse_at_W", pulses0 - p_start, 1);
        check("busy_end", busy0, 0);
        xp0 = 1'b1; xm0 = 1'b0;  // idle inputs must be ignored
        tick();
        check("single_pulse", yv0, 0);
        repeat (5) tick();
        xp0 = 1'b0;
        check("y_hold", y0, e);
    endtask

    initial begin
        int p, e, yprev;
        int cpats [5];
        vecs[0] = '{0, 256, 1'b0};
        vecs[1] = '{1, -256, 1'b0};
        vecs[2] = '{2, 0, 1'b0};
        vecs[3] = '{3, 128, 1'b0};
        vecs[4] = '{4, -64, 1'b0};
        vecs[5] = '{5, 0, 1'b1};
        cpats[0] = 0; cpats[1] = 0; cpats[2] = 6; cpats[3] = 5; cpats[4] = 3;

        nRST = 1'b0;
        start0 = 1'b0; clear0 = 1'b0; xp0 = 1'b0; xm0 = 1'b0;
        start1 = 1'b0; clear1 = 1'b0; xp1 = 1'b0; xm1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_y0", y0, 0);
        check("rst_yv0", yv0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_y1", y1, 0);
        check("rst_busy1", busy1, 0);
        @(negedge clk);
        nRST = 1'b1;
        tick();

        // Table-driven one-shot windows
        for (int v = 0; v < 6; v++) begin
            run_oneshot(vecs[v].pat, vecs[v].exp_y, vecs[v].use_model);
        end

        // Clear at sample 100: no result, y held
        yprev = last_y0;
        start0 = 1'b1; tick(); start0 = 1'b0;
        p = pulses0;
        for (int i = 0; i < 100; i++) begin
            xp0 = 1'b1; tick();
        end
        clear0 = 1'b1; tick(); clear0 = 1'b0; xp0 = 1'b0;
        check("clear_busy", busy0, 0);
        check("clear_y_kept", y0, yprev);
        repeat (300) tick();
        check("clear_no_pulse", pulses0 - p, 0);

        // Clear on the window-end edge: still no result
        start0 = 1'b1; tick(); start0 = 1'b0;
        p = pulses0;
        for (int i = 0; i < W; i++) begin
            xp0 = 1'b1;
            clear0 = (i == W - 1);
            tick();
        end
        clear0 = 1'b0; xp0 = 1'b0;
        tick();
        check("clear_end_no_pulse", pulses0 - p, 0);
        check("clear_end_busy", busy0, 0);
        check("clear_end_y_kept", y0, yprev);

        // Start and clear together in IDLE: stays idle
        start0 = 1'b1; clear0 = 1'b1; tick();
        start0 = 1'b0; clear0 = 1'b0;
        check("start_clear_busy", busy0, 0);
        p = pulses0;
        repeat (W + 4) tick();
        check("start_clear_no_pulse", pulses0 - p, 0);

        // Continuous windows, back to back
        start1 = 1'b1; tick(); start1 = 1'b0;
        p = pulses1;
        for (int w = 0; w < 5; w++) begin
            fill_window(cpats[w], e);
            q1.push_back(e);
            for (int i = 0; i < W; i++) begin
                {xp1, xm1} = win_bits[i];
                tick();
            end
            check("cont_busy", busy1, 1);
        end
        check("cont_pulse_count", pulses1 - p, 5);
        clear1 = 1'b1; xp1 = 1'b0; xm1 = 1'b0; tick(); clear1 = 1'b0;
        check("cont_clear_busy", busy1, 0);

        // Reset in the middle of a window
        start0 = 1'b1; tick(); start0 = 1'b0;
        for (int i = 0; i < 50; i++) begin
            xp0 = 1'b1; tick();
        end
        nRST = 1'b0;
        #1;
        check("midrst_y0", y0, 0);
        check("midrst_yv0", yv0, 0);
        check("midrst_busy0", busy0, 0);
        check("midrst_y1", y1, 0);
        xp0 = 1'b0;
        @(negedge clk);
        nRST = 1'b1;
        tick();
        run_oneshot(0, 256, 1'b0);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
